// File: rtl/pipe_mux_scan_if.sv
// pipe_mux_scan_if: groups the sample-side and consumer-side handshake
// signals of pipe_mux_scan. The master modport belongs to whoever drives the
// samples and consumes the output. The slave modport belongs to the mux.
// Optional macro PIPE_MUX_SEL_CHECK_EN adds the out_err flag.
interface pipe_mux_scan_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 16
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [WIDTH*CHANNELS-1:0] in_data;
  logic [SEL_W-1:0]          sel;
  logic                      scan_en;
  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;
  logic                      out_valid;
  logic                      out_ready;
`ifdef PIPE_MUX_SEL_CHECK_EN
  logic                      out_err;
`endif

  modport master (
    output in_data, sel, scan_en, in_valid, out_ready,
    input  in_ready, out_data, out_chan, out_valid
`ifdef PIPE_MUX_SEL_CHECK_EN
    , input out_err
`endif
  );

  modport slave (
    input  in_data, sel, scan_en, in_valid, out_ready,
    output in_ready, out_data, out_chan, out_valid
`ifdef PIPE_MUX_SEL_CHECK_EN
    , output out_err
`endif
  );
endinterface

// File: rtl/pipe_mux_scan.sv
// pipe_mux_scan: pipelined N:1 multiplexer built from registered 4:1 levels.
// Each sample carries its own effective select down the pipe, so mode
// changes never disturb samples that are already in flight. An auto-scan
// counter can replace the direct select so that all channels are walked in turn.
// Optional macro PIPE_MUX_SEL_CHECK_EN adds out_err, which flags out-of-range selects.
module pipe_mux_scan #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 16
) (
  input logic            clk,
  input logic            rst,
  pipe_mux_scan_if.slave bus
);
  localparam int SEL_W  = $clog2(CHANNELS);
  localparam int LEVELS = (SEL_W + 1) / 2;
  localparam int SELP_W = 2 * LEVELS;
  localparam int PAD    = 1 << SELP_W;
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CHANNELS - 1);
  localparam logic [SEL_W:0]   CH_LIMIT = (SEL_W + 1)'(CHANNELS);

  logic              stall;
  logic              accept;
  logic              scan_en_d;
  logic              scan_rise;
  logic [SEL_W-1:0]  scan_cnt;
  logic [SEL_W-1:0]  scan_base;
  logic [SEL_W-1:0]  eff_sel;
  logic [SELP_W-1:0] eff_sel_p;
  logic [WIDTH-1:0]  leaf [PAD];

  assign stall       = bus.out_valid & ~bus.out_ready;
  assign bus.in_ready = ~stall;
  assign accept      = bus.in_valid & ~stall;
  assign scan_rise   = bus.scan_en & ~scan_en_d;
  assign scan_base   = scan_rise ? '0 : scan_cnt;
  assign eff_sel     = bus.scan_en ? scan_base : bus.sel;

  // Zero-extend the select to a whole number of 2-bit level fields
  always_comb begin
    eff_sel_p = '0;
    eff_sel_p[SEL_W-1:0] = eff_sel;
  end

  // Scan counter: steps on accepted scan samples and restarts at 0 when scan mode is entered
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt  <= '0;
      scan_en_d <= 1'b0;
    end else begin
      scan_en_d <= bus.scan_en;
      if (bus.scan_en && accept) begin
        scan_cnt <= (scan_base == LAST_CH) ? '0 : scan_base + 1'b1;
      end else if (scan_rise) begin
        scan_cnt <= '0;
      end
    end
  end

  // Leaves beyond CHANNELS are tied to zero so the tree is always a full power of 4
  for (genvar i = 0; i < PAD; i++) begin : g_leaf
    if (i < CHANNELS) begin : g_pop
      assign leaf[i] = bus.in_data[i*WIDTH +: WIDTH];
    end else begin : g_pad
      assign leaf[i] = '0;
    end
  end

`ifdef PIPE_MUX_SEL_CHECK_EN
  logic sel_err;
  assign sel_err = accept & ({1'b0, eff_sel} >= CH_LIMIT);
`endif

  for (genvar k = 0; k < LEVELS; k++) begin : lv
    localparam int NOUT = PAD >> (2 * (k + 1));

    logic [WIDTH-1:0]  d_in   [4*NOUT];
    logic [WIDTH-1:0]  nxt    [NOUT];
    logic [WIDTH-1:0]  q_data [NOUT];
    logic              v_in;
    logic              q_valid;
    logic [SELP_W-1:0] s_in;
    logic [SELP_W-1:0] q_sel;
    logic [1:0]        sub;

    if (k == 0) begin : g_src
      assign d_in = leaf;
      assign v_in = accept;
      assign s_in = eff_sel_p;
    end else begin : g_src
      assign d_in = lv[k-1].q_data;
      assign v_in = lv[k-1].q_valid;
      assign s_in = lv[k-1].q_sel;
    end

    assign sub = s_in[2*k+1 -: 2];

    for (genvar j = 0; j < NOUT; j++) begin : g_mux
      assign nxt[j] = sub[1] ? (sub[0] ? d_in[4*j+3] : d_in[4*j+2])
                             : (sub[0] ? d_in[4*j+1] : d_in[4*j]);
    end

    // Level register: loads the reduced group when the pipe moves, holds while stalled
    always_ff @(posedge clk) begin
      if (rst) begin
        q_valid <= 1'b0;
        q_sel   <= '0;
        q_data  <= '{default: '0};
      end else if (!stall) begin
        q_valid <= v_in;
        q_sel   <= s_in;
        q_data  <= nxt;
      end
    end

`ifdef PIPE_MUX_SEL_CHECK_EN
    logic e_in;
    logic q_err;
    if (k == 0) begin : g_err_src
      assign e_in = sel_err;
    end else begin : g_err_src
      assign e_in = lv[k-1].q_err;
    end

    // Out-of-range flag travels in lockstep with its sample
    always_ff @(posedge clk) begin
      if (rst) begin
        q_err <= 1'b0;
      end else if (!stall) begin
        q_err <= e_in;
      end
    end
`endif
  end

  assign bus.out_data  = lv[LEVELS-1].q_data[0];
  assign bus.out_valid = lv[LEVELS-1].q_valid;
  assign bus.out_chan  = lv[LEVELS-1].q_sel[SEL_W-1:0];
`ifdef PIPE_MUX_SEL_CHECK_EN
  assign bus.out_err   = lv[LEVELS-1].q_err;
`endif

endmodule

// File: tb/tb_pipe_mux_scan.sv
// tb_pipe_mux_scan: directed bench for pipe_mux_scan. It uses a 16-channel
// instance for the main behaviour and a 10-channel instance for out-of-range selects.
// Channel i always carries 0x10+i. Define PIPE_MUX_SEL_CHECK_EN to check out_err as well.
module tb_pipe_mux_scan;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_mux_scan_if #(.WIDTH(8), .CHANNELS(16)) bus16 ();
  pipe_mux_scan_if #(.WIDTH(8), .CHANNELS(10)) bus10 ();

  pipe_mux_scan #(.WIDTH(8), .CHANNELS(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  pipe_mux_scan #(.WIDTH(8), .CHANNELS(10)) dut10 (.clk(clk), .rst(rst), .bus(bus10));

  // Mode-switch stream: four scan samples, one direct sel=3, then scan re-entered
  logic       ms_scan [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [3:0] ms_exp  [7] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd3, 4'd0, 4'd1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] s,
                               input logic scan, input logic ordy);
    bus16.in_valid  = v;
    bus16.sel       = s;
    bus16.scan_en   = scan;
    bus16.out_ready = ordy;
    #1;
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic ev,
                             input logic [7:0] ed, input logic [3:0] ec);
    checkVal({tag, "/valid"}, 32'(bus16.out_valid), 32'(ev));
    if (ev) begin
      checkVal({tag, "/data"}, 32'(bus16.out_data), 32'(ed));
      checkVal({tag, "/chan"}, 32'(bus16.out_chan), 32'(ec));
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 16; i++) bus16.in_data[i*8 +: 8] = 8'(8'h10 + i);
    for (int i = 0; i < 10; i++) bus10.in_data[i*8 +: 8] = 8'(8'h10 + i);
    bus10.in_valid  = 1'b0;
    bus10.sel       = 4'd0;
    bus10.scan_en   = 1'b0;
    bus10.out_ready = 1'b1;
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state
    checkVal("rst_out_valid", 32'(bus16.out_valid), 32'd0);
    checkVal("rst_out_data",  32'(bus16.out_data),  32'd0);
    checkVal("rst_out_chan",  32'(bus16.out_chan),  32'd0);
    checkVal("rst_in_ready",  32'(bus16.in_ready),  32'd1);
    checkVal("rst10_out_valid", 32'(bus10.out_valid), 32'd0);
`ifdef PIPE_MUX_SEL_CHECK_EN
    checkVal("rst10_out_err", 32'(bus10.out_err), 32'd0);
`endif

    // Single direct-select pulse: two-cycle latency
    applyStimulus(1'b1, 4'd5, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 4'd5, 1'b0, 1'b1);
    checkVal("pulse_t1_valid", 32'(bus16.out_valid), 32'd0);
    tick();
    checkOutput("pulse_t2", 1'b1, 8'h15, 4'd5);

    // Back-to-back direct selects 0, 15, 7
    applyStimulus(1'b1, 4'd0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 4'd15, 1'b0, 1'b1);
    tick();
    checkOutput("b2b_0", 1'b1, 8'h10, 4'd0);
    applyStimulus(1'b1, 4'd7, 1'b0, 1'b1);
    tick();
    checkOutput("b2b_15", 1'b1, 8'h1F, 4'd15);
    applyStimulus(1'b0, 4'd7, 1'b0, 1'b1);
    tick();
    checkOutput("b2b_7", 1'b1, 8'h17, 4'd7);
    tick();
    checkOutput("b2b_idle", 1'b0, 8'h00, 4'd0);

    // Scan mode for 18 accepted samples: 0..15 then wraps to 0, 1
    for (int i = 0; i <= 18; i++) begin
      applyStimulus((i < 18), 4'd0, 1'b1, 1'b1);
      tick();
      if (i >= 1) checkOutput($sformatf("scan_%0d", i - 1), 1'b1,
                              8'(8'h10 + ((i - 1) % 16)), 4'((i - 1) % 16));
    end

    // Backpressure: out_ready low for three edges while ch1 is presented
    applyStimulus(1'b1, 4'd1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 4'd2, 1'b0, 1'b1);
    tick();
    checkOutput("bp_pre", 1'b1, 8'h11, 4'd1);
    applyStimulus(1'b1, 4'd3, 1'b0, 1'b0);
    checkVal("bp_in_ready_low", 32'(bus16.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("bp_hold_%0d", i), 1'b1, 8'h11, 4'd1);
    end
    checkVal("bp_in_ready_held", 32'(bus16.in_ready), 32'd0);
    applyStimulus(1'b1, 4'd3, 1'b0, 1'b1);
    checkVal("bp_in_ready_rel", 32'(bus16.in_ready), 32'd1);
    tick();
    checkOutput("bp_post_2", 1'b1, 8'h12, 4'd2);
    applyStimulus(1'b1, 4'd4, 1'b0, 1'b1);
    tick();
    checkOutput("bp_post_3", 1'b1, 8'h13, 4'd3);
    applyStimulus(1'b0, 4'd4, 1'b0, 1'b1);
    tick();
    checkOutput("bp_post_4", 1'b1, 8'h14, 4'd4);
    tick();
    checkOutput("bp_idle", 1'b0, 8'h00, 4'd0);

    // Reset with two scan samples in flight
    applyStimulus(1'b1, 4'd0, 1'b1, 1'b1);
    tick();
    tick();
    checkOutput("rst_mid_pre", 1'b1, 8'h10, 4'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checkVal("rst_mid_valid", 32'(bus16.out_valid), 32'd0);
    checkVal("rst_mid_data",  32'(bus16.out_data),  32'd0);
    tick();
    checkVal("rst_mid_no_stale", 32'(bus16.out_valid), 32'd0);
    tick();
    checkOutput("rst_mid_restart", 1'b1, 8'h10, 4'd0);

    // Mode switch: scan continues from 2 to 5, direct sel=3, then scan restarts at 0
    for (int i = 0; i < 8; i++) begin
      if (i < 7) applyStimulus(1'b1, 4'd3, ms_scan[i], 1'b1);
      else       applyStimulus(1'b0, 4'd3, 1'b1, 1'b1);
      tick();
      if (i >= 1) checkOutput($sformatf("mode_%0d", i - 1), 1'b1,
                              8'(8'h10 + ms_exp[i-1]), ms_exp[i-1]);
    end

    // Out-of-range select on the 10-channel instance
    bus10.in_valid = 1'b1;
    bus10.sel      = 4'd12;
    tick();
    bus10.sel      = 4'd9;
    tick();
    bus10.in_valid = 1'b0;
    checkVal("oor12_valid", 32'(bus10.out_valid), 32'd1);
    checkVal("oor12_data",  32'(bus10.out_data),  32'd0);
    checkVal("oor12_chan",  32'(bus10.out_chan),  32'd12);
`ifdef PIPE_MUX_SEL_CHECK_EN
    checkVal("oor12_err",   32'(bus10.out_err),   32'd1);
`endif
    tick();
    checkVal("ch9_valid", 32'(bus10.out_valid), 32'd1);
    checkVal("ch9_data",  32'(bus10.out_data),  32'h19);
    checkVal("ch9_chan",  32'(bus10.out_chan),  32'd9);
`ifdef PIPE_MUX_SEL_CHECK_EN
    checkVal("ch9_err",   32'(bus10.out_err),   32'd0);
`endif
    tick();
    checkVal("oor_idle_valid", 32'(bus10.out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_mux_scan.md
Name: pipe_mux_scan

Overview:
- Parametrised, pipelined N:1 multiplexer built as a tree of registered 4:1 levels.
- Next generation of the team's combinational 16:1 mux tree: configurable channel count and data width, a valid/ready handshake with backpressure, and an auto-scan mode that walks all channels in turn.
- Sits between a bank of parallel sample sources and a single serial consumer, e.g. a sampler or a display driver.

Parameters:
- WIDTH, 8: data bits per channel.
- CHANNELS, 16: number of input channels; legal range 2..256.
- Localparam SEL_W = clog2(CHANNELS): select and channel-tag width.
- Localparam LEVELS = ceil(log4(CHANNELS)): pipeline depth; 2 for the defaults.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_data  input  WIDTH*CHANNELS  flat bus; channel i occupies bits [i*WIDTH +: WIDTH].
- sel  input  SEL_W  channel select, used when scan_en=0.
- scan_en  input  1  1 = auto-scan mode; 0 = direct select.
- in_valid  input  1  a sample of in_data is offered this cycle.
- in_ready  output  1  the block accepts a sample this cycle.
- out_data  output  WIDTH  selected channel data.
- out_chan  output  SEL_W  index of the channel in out_data.
- out_valid  output  1  out_data and out_chan are valid.
- out_ready  input  1  the consumer accepts the output this cycle.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: on a clock edge with rst=1, all pipeline valid bits, out_valid, out_data, out_chan and the scan counter clear to 0. Reset overrides every other input. Data in flight when reset asserts is discarded; nothing is emitted for it.
- Stall: stall = out_valid & ~out_ready. in_ready = ~stall, combinational.
- Accept: a sample is accepted when in_valid & in_ready.
- Pipeline hold: while stall=1, every stage holds its contents, including out_data, out_chan and out_valid.
- Bubbles: when not stalled, each stage loads from the previous one. A cycle with no accepted sample inserts a bubble (valid=0).
- Effective select: eff_sel = scan_cnt when scan_en=1, otherwise sel. It is sampled at acceptance and travels down the pipe with its data.
- Level k (0..LEVELS-1): reduces groups of 4 using eff_sel bits [2k+1:2k]. The unused upper select bits are carried registered alongside the data.
- Unpopulated leaves: channels at index ≥ CHANNELS read as 0.
- Latency: exactly LEVELS cycles from acceptance to out_valid=1, absent stalls. Throughput is one sample per cycle. out_chan = eff_sel of that sample.
- Out-of-range select: direct-mode sel ≥ CHANNELS yields out_data=0 and out_chan=sel.
- Scan counter, increment: advances by 1 on each accepted sample while scan_en=1, wrapping from CHANNELS-1 to 0.
- Scan counter, hold and restart: holds when no sample is accepted. Reloads to 0 on the cycle after scan_en rises from 0 to 1, so the first scanned sample is channel 0.
- Mode changes mid-stream: samples already in the pipe complete with their captured eff_sel. Only new acceptances see the new mode.

Optional Feature:
- Macro PIPE_MUX_SEL_CHECK_EN.
- When defined: adds output out_err (1 bit, reset 0). It is set for an output sample whose eff_sel ≥ CHANNELS, is pipelined and held exactly like out_data, and is valid only with out_valid.
- When not defined: port out_err is absent, and out-of-range selects silently produce out_data=0.
- Scan mode never raises out_err.

Test Plan:
- Direct select: CHANNELS=16, WIDTH=8, channel i = 0x10+i, out_ready=1; in_valid pulse with sel=5 at cycle t → out_valid=1 at t+2 with out_data=0x15 and out_chan=5; back-to-back sel=0,15,7 → outputs 0x10,0x1F,0x17 on consecutive cycles.
- Scan wrap: scan_en=1, in_valid=1 for 18 cycles → out_chan sequence 0..15,0,1 with matching data 0x10..0x1F,0x10,0x11.
- Backpressure: deassert out_ready for 3 cycles while out_valid=1 → in_ready=0, outputs frozen for those 3 cycles, and no sample is lost or duplicated after release.
- Reset mid-operation: rst=1 for one edge with 2 samples in flight → out_valid=0 the next cycle, no stale output emitted, scan counter restarts at 0.
- Out-of-range select: CHANNELS=10, sel=12 → out_data=0, out_chan=12; with PIPE_MUX_SEL_CHECK_EN defined, out_err=1. With sel=9 → data of channel 9, out_err=0.
- Mode switch: scan_cnt=6, then scan_en falls and sel=3 → the next accepted sample gives out_chan=3; scan_en re-rises → the following scanned output is channel 0.
